// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;
   localparam logic [31:0] INSTR_BYTES      = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_word_t;

   // Word-align a fetch address; the low two bits are never meaningful.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & INSTR_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word that decode could not take.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        nRst,
   input  logic        load_i,
   input  fetch_word_t load_word_i,
   input  logic        drain_i,
   input  logic        flush_i,
   output logic        valid_o,
   output fetch_word_t word_o
);

   logic        valid_q, valid_d;
   fetch_word_t word_q, word_d;

   // Next entry: a flush beats a load, a load beats a drain.
   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         word_d  = load_word_i;
      end else if (drain_i) begin
         valid_d = 1'b0;
      end
   end

   // Entry register, cleared by reset.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         valid_q <= 1'b0;
         word_q  <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
      end
   end

   assign valid_o = valid_q;
   assign word_o  = word_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, memory request FSM, output slot and skid.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        nRst,
   input  logic        iStall,
   input  logic        iBranchEn,
   input  logic [31:0] iBranchAddr,
   output logic        oImemEn,
   output logic [31:0] oImemAddr,
   input  logic [31:0] iImemData,
   input  logic        iImemStall,
   output logic        oValid,
   output logic [31:0] oPC,
   output logic [31:0] oInstr
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  ptgt_q, ptgt_d;
   logic         valid_q, valid_d;
   fetch_word_t  slot_q, slot_d;

   logic         skid_load, skid_drain, skid_flush, skid_valid;
   fetch_word_t  skid_word;
   fetch_word_t  fetched;
   logic         req_active, ack, slot_open, slot_taken;
   logic [31:0]  br_tgt;

   // The request is registered state only; reset forces it off at once so an
   // in-flight access is abandoned without waiting for a clock.
   assign req_active = (state_q == REQ) || (state_q == DRAIN);
   assign oImemEn    = nRst & req_active;
   assign oImemAddr  = pc_q;
   assign ack        = oImemEn & ~iImemStall;
   assign slot_taken = valid_q & ~iStall;
   assign slot_open  = ~valid_q | ~iStall;
   assign br_tgt     = align_pc(iBranchAddr);
   assign fetched    = '{pc: pc_q, instr: iImemData};

   // Next-state, PC, pending target and slot update; redirects win over all.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ptgt_d     = ptgt_q;
      valid_d    = valid_q;
      slot_d     = slot_q;
      skid_load  = 1'b0;
      skid_drain = 1'b0;
      skid_flush = 1'b0;

      if (slot_taken) valid_d = 1'b0;

      if (iBranchEn) begin
         valid_d    = 1'b0;
         skid_flush = 1'b0 | 1'b1;
         if (!req_active || ack) begin
            // Bus is free (or the access completes now): retarget directly.
            pc_d    = br_tgt;
            state_d = REQ;
         end else begin
            // Address must hold until the stalled access acks.
            ptgt_d  = br_tgt;
            state_d = DRAIN;
         end
      end else begin
         unique case (state_q)
            REQ: begin
               if (ack) begin
                  pc_d = pc_q + INSTR_BYTES;
                  if (slot_open && !skid_valid) begin
                     slot_d  = fetched;
                     valid_d = 1'b1;
                  end else begin
                     skid_load = 1'b1;
                     state_d   = HOLD;
                  end
               end
            end
            DRAIN: begin
               if (ack) begin
                  pc_d    = ptgt_q;
                  state_d = REQ;
               end
            end
            HOLD: begin
               if (!iStall) begin
                  slot_d     = skid_word;
                  valid_d    = 1'b1;
                  skid_drain = 1'b1;
                  state_d    = REQ;
               end
            end
            default: state_d = REQ;
         endcase
      end
   end

   // State, PC, pending target and output slot registers.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         ptgt_q  <= '0;
         valid_q <= 1'b0;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ptgt_q  <= ptgt_d;
         valid_q <= valid_d;
         slot_q  <= slot_d;
      end
   end

   fetch_skid_buf u_skid (
      .clk         (clk),
      .nRst        (nRst),
      .load_i      (skid_load),
      .load_word_i (fetched),
      .drain_i     (skid_drain),
      .flush_i     (skid_flush),
      .valid_o     (skid_valid),
      .word_o      (skid_word)
   );

   assign oValid = valid_q;
   assign oPC    = slot_q.pc;
   assign oInstr = slot_q.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model plus directed scenarios.
module tb_instr_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] XOR_K  = 32'hA5A5_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } word_t;

   logic        clk = 1'b0;
   logic        nRst = 1'b1;
   logic        iStall = 1'b0;
   logic        iBranchEn = 1'b0;
   logic [31:0] iBranchAddr = '0;
   logic        iImemStall = 1'b0;
   logic [31:0] iImemData = '0;
   logic        oImemEn, oValid;
   logic [31:0] oImemAddr, oPC, oInstr;

   int n_chk = 0;
   int n_err = 0;
   int wait_cfg = 0;
   int wcnt = 0;

   // Reference model: words fetched but not yet consumed, oldest first.
   word_t       mq[$];
   logic [31:0] m_pc   = RST_PC;
   logic [31:0] m_ptgt = '0;
   bit          m_pend = 1'b0;

   instr_fetch #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .nRst        (nRst),
      .iStall      (iStall),
      .iBranchEn   (iBranchEn),
      .iBranchAddr (iBranchAddr),
      .oImemEn     (oImemEn),
      .oImemAddr   (oImemAddr),
      .iImemData   (iImemData),
      .iImemStall  (iImemStall),
      .oValid      (oValid),
      .oPC         (oPC),
      .oInstr      (oInstr)
   );

   always #5 clk = ~clk;

   // Fetch requests run while there is room for the word, or a redirect is waiting.
   function automatic bit m_en();
      return (mq.size() < 2) || m_pend;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = RST_PC;
      m_ptgt = '0;
      m_pend = 1'b0;
   endtask

   task automatic model_step();
      bit          en, ack;
      logic [31:0] tgt;
      en  = m_en();
      ack = en && !iImemStall;
      if (iBranchEn) begin
         tgt = iBranchAddr & 32'hFFFF_FFFC;
         mq.delete();
         if (en && !ack) begin
            m_pend = 1'b1;
            m_ptgt = tgt;
         end else begin
            m_pend = 1'b0;
            m_pc   = tgt;
         end
      end else begin
         if (mq.size() > 0 && !iStall) void'(mq.pop_front());
         if (ack) begin
            if (m_pend) begin
               m_pc   = m_ptgt;
               m_pend = 1'b0;
            end else begin
               mq.push_back(word_t'{pc: m_pc, instr: iImemData});
               m_pc = m_pc + 32'd4;
            end
         end
      end
   endtask

   // One clock: memory responds (wait_cfg stall cycles per access), model advances.
   task automatic tick();
      logic en_pre;
      iImemStall = (wcnt < wait_cfg);
      iImemData  = oImemAddr ^ XOR_K;
      en_pre     = oImemEn;
      @(posedge clk);
      if (!nRst) begin
         model_reset();
         wcnt = 0;
      end else begin
         model_step();
         if (en_pre && !iImemStall) wcnt = 0;
         else if (en_pre) wcnt++;
      end
      #1;
   endtask

   task automatic do_reset();
      nRst = 1'b0;
      model_reset();
      wcnt = 0;
      #1;
      tick();
      nRst = 1'b1;
      #1;
   endtask

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      check("imem_en", {31'd0, oImemEn}, {31'd0, (nRst && m_en())});
      if (nRst && m_en()) check("imem_addr", oImemAddr, m_pc);
      check("valid", {31'd0, oValid}, {31'd0, (mq.size() > 0)});
      if (mq.size() > 0) begin
         check("out_pc", oPC, mq[0].pc);
         check("out_instr", oInstr, mq[0].instr);
      end
   end

   logic [19:0] stall_pat = 20'b0110_0011_1001_1100_0101;

   initial begin
      // Reset values.
      #1 nRst = 1'b0;
      #1;
      check("rst_en", {31'd0, oImemEn}, 32'd0);
      check("rst_valid", {31'd0, oValid}, 32'd0);
      check("rst_pc", oPC, 32'd0);
      check("rst_instr", oInstr, 32'd0);
      tick();
      tick();
      nRst = 1'b1;
      #1;
      check("rel_en", {31'd0, oImemEn}, 32'd1);
      check("rel_addr", oImemAddr, 32'h0000_0100);

      // Streaming, zero-wait memory.
      tick();
      check("str_addr1", oImemAddr, 32'h0000_0104);
      check("str_valid1", {31'd0, oValid}, 32'd1);
      check("str_pc1", oPC, 32'h0000_0100);
      check("str_instr1", oInstr, 32'hA5A5_0100);
      tick();
      check("str_addr2", oImemAddr, 32'h0000_0108);
      check("str_pc2", oPC, 32'h0000_0104);
      check("str_instr2", oInstr, 32'hA5A5_0104);
      repeat (3) tick();

      // Three wait states per access.
      wait_cfg = 3;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         check("ws_addr_hold", oImemAddr, 32'h0000_0100);
         check("ws_en_hold", {31'd0, oImemEn}, 32'd1);
         tick();
      end
      check("ws_addr_last", oImemAddr, 32'h0000_0100);
      check("ws_valid_pre", {31'd0, oValid}, 32'd0);
      tick();
      check("ws_addr_next", oImemAddr, 32'h0000_0104);
      check("ws_valid", {31'd0, oValid}, 32'd1);
      check("ws_pc", oPC, 32'h0000_0100);

      // Redirect during the second wait cycle of the 0x104 access.
      tick();
      iBranchEn = 1'b1;
      iBranchAddr = 32'h0000_2000;
      tick();
      iBranchEn = 1'b0;
      check("drn_addr_hold", oImemAddr, 32'h0000_0104);
      check("drn_valid", {31'd0, oValid}, 32'd0);
      tick();
      tick();
      check("drn_addr_tgt", oImemAddr, 32'h0000_2000);
      check("drn_discard", {31'd0, oValid}, 32'd0);
      repeat (3) tick();
      check("drn_wait_valid", {31'd0, oValid}, 32'd0);
      tick();
      check("drn_first_valid", {31'd0, oValid}, 32'd1);
      check("drn_first_pc", oPC, 32'h0000_2000);
      check("drn_first_instr", oInstr, 32'hA5A5_2000);

      // Back-pressure into the skid.
      wait_cfg = 0;
      do_reset();
      tick();
      check("bp_pc0", oPC, 32'h0000_0100);
      iStall = 1'b1;
      tick();
      check("bp_en_off", {31'd0, oImemEn}, 32'd0);
      check("bp_pc_hold", oPC, 32'h0000_0100);
      tick();
      check("bp_pc_hold2", oPC, 32'h0000_0100);
      iStall = 1'b0;
      tick();
      check("bp_pc_skid", oPC, 32'h0000_0104);
      check("bp_addr_resume", oImemAddr, 32'h0000_0108);
      tick();
      check("bp_pc_next", oPC, 32'h0000_0108);

      // Redirect while holding a skid word, unaligned target.
      iStall = 1'b1;
      tick();
      check("hold_en_off", {31'd0, oImemEn}, 32'd0);
      iBranchEn = 1'b1;
      iBranchAddr = 32'h0000_2003;
      tick();
      iBranchEn = 1'b0;
      check("hbr_valid", {31'd0, oValid}, 32'd0);
      check("hbr_addr", oImemAddr, 32'h0000_2000);
      iStall = 1'b0;
      tick();
      check("hbr_pc", oPC, 32'h0000_2000);
      tick();
      check("hbr_no_skid", oPC, 32'h0000_2004);

      // Reset in the middle of a waited access with a live slot.
      wait_cfg = 3;
      iStall = 1'b1;
      tick();
      tick();
      check("mrst_pre_valid", {31'd0, oValid}, 32'd1);
      nRst = 1'b0;
      model_reset();
      wcnt = 0;
      #1;
      check("mrst_en", {31'd0, oImemEn}, 32'd0);
      check("mrst_valid", {31'd0, oValid}, 32'd0);
      check("mrst_pc", oPC, 32'd0);
      iStall = 1'b0;
      tick();
      nRst = 1'b1;
      #1;
      check("mrst_addr", oImemAddr, 32'h0000_0100);
      repeat (6) tick();

      // PC wrap at the top of the address space.
      wait_cfg = 0;
      iBranchEn = 1'b1;
      iBranchAddr = 32'hFFFF_FFFC;
      tick();
      iBranchEn = 1'b0;
      check("wrap_addr_top", oImemAddr, 32'hFFFF_FFFC);
      tick();
      check("wrap_addr_zero", oImemAddr, 32'h0000_0000);
      check("wrap_pc", oPC, 32'hFFFF_FFFC);
      tick();
      check("wrap_pc0", oPC, 32'h0000_0000);
      check("wrap_instr0", oInstr, 32'hA5A5_0000);

      // Mixed stall pattern with one-wait memory and two redirects.
      wait_cfg = 1;
      for (int i = 0; i < 20; i++) begin
         iStall = stall_pat[i];
         iBranchEn = (i == 7) || (i == 13);
         iBranchAddr = 32'h0000_3000 + 32'(i * 16);
         tick();
      end
      iStall = 1'b0;
      iBranchEn = 1'b0;
      repeat (6) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
